// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: size codes, FSM state
// encoding and the misalignment rule.
package lsu_pkg;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;

    // Bit of the access type that selects zero-extension over sign-extension.
    localparam int LS_U = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    // A half may start at any lane but the last; a word must start at lane 0.
    function automatic logic ls_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            LS_H:    mis = (off == 2'd3);
            LS_W:    mis = (off != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Merges two consecutive aligned words into the value that starts at byte
// offset 'off', then truncates and sign/zero-extends it per the access type.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  off,
    input  logic [2:0]  rtype,
    output logic [31:0] result
);

    logic [63:0] pair;
    logic [31:0] m;

    assign pair = {hi, lo};
    assign m    = pair[{1'b0, off, 3'b000} +: 32];

    always_comb begin
        result = m;
        case (rtype[1:0])
            LS_B:    result = rtype[LS_U] ? {24'h0, m[7:0]}  : {{24{m[7]}}, m[7:0]};
            LS_H:    result = rtype[LS_U] ? {16'h0, m[15:0]} : {{16{m[15]}}, m[15:0]};
            default: result = m;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller driving the data-memory port. Aligned accesses take
// one memory cycle; misaligned loads take two word reads and a merge.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // valid, once raised, is held with stable payload until that edge.
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_misalign,
    output logic          mem_W_en,
    output logic          mem_R_en,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_RW_type,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ACC1 = ST_ACC1;
    localparam logic [1:0] ACC2 = ST_ACC2;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]    state_q, state_d;
    logic          we_q;
    logic [2:0]    type_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          mis_q;
    logic          misexc_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] merged;
    logic          mis_now;
    logic [AW-1:0] word_addr;

    assign mis_now   = ls_misaligned(req_type[1:0], req_addr[1:0]);
    assign word_addr = {addr_q[AW-1:2], 2'b00};
    assign req_ready = (state_q == IDLE);
    assign dbg_state = state_q;

    lsu_align u_align (
        .hi     (mem_RD),
        .lo     (lo_q),
        .off    (addr_q[1:0]),
        .rtype  (type_q),
        .result (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = (req_we && mis_now) ? RESP : ACC1;
            ACC1: state_d = mis_q ? ACC2 : RESP;
            ACC2: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            type_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            mis_q    <= 1'b0;
            misexc_q <= 1'b0;
            lo_q     <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        type_q   <= req_type;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        // Only loads take the two-read path; misaligned stores go straight to RESP.
                        mis_q    <= mis_now && !req_we;
                        misexc_q <= mis_now && req_we;
                        rdata_q  <= '0;
                    end
                end
                ACC1: begin
                    if (mis_q)      lo_q    <= mem_RD;
                    else if (!we_q) rdata_q <= mem_RD;
                end
                ACC2: rdata_q <= merged;
                default: ;
            endcase
        end
    end

    // Enables are gated by reset so a reset landing mid-access never writes.
    always_comb begin
        mem_W_en    = 1'b0;
        mem_R_en    = 1'b0;
        mem_addr    = '0;
        mem_RW_type = 3'b000;
        mem_WD      = '0;
        case (state_q)
            ACC1: begin
                mem_addr    = mis_q ? word_addr : addr_q;
                mem_RW_type = mis_q ? {1'b0, LS_W} : type_q;
                if (we_q) begin
                    mem_W_en = !rst;
                    mem_WD   = wdata_q;
                end else begin
                    mem_R_en = !rst;
                end
            end
            ACC2: begin
                mem_addr    = word_addr + AW'(4);
                mem_RW_type = {1'b0, LS_W};
                mem_R_en    = !rst;
            end
            default: ;
        endcase
    end

    assign rsp_valid    = (state_q == RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign rsp_misalign = rsp_valid && misexc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl with a behavioural byte-addressed data memory as responder.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        mem_W_en, mem_R_en;
    logic [31:0] mem_addr;
    logic [2:0]  mem_RW_type;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;

    lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign),
        .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
        .mem_RW_type(mem_RW_type), .mem_WD(mem_WD), .mem_RD(mem_RD),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    // data memory model: 256 bytes, little-endian, lane-select + extend on read
    logic [7:0]  mem [0:255];
    logic [7:0]  ma;
    logic [7:0]  b0, b1, b2, b3;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_count = 0;

    assign ma = mem_addr[7:0];
    assign b0 = mem[ma];
    assign b1 = mem[ma + 8'd1];
    assign b2 = mem[ma + 8'd2];
    assign b3 = mem[ma + 8'd3];

    always_comb begin
        mem_RD = '0;
        case (mem_RW_type[1:0])
            2'b00:   mem_RD = mem_RW_type[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_RD = mem_RW_type[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_RD = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr]        <= poke_data[7:0];
            mem[poke_addr + 8'd1] <= poke_data[15:8];
            mem[poke_addr + 8'd2] <= poke_data[23:16];
            mem[poke_addr + 8'd3] <= poke_data[31:24];
        end
        if (mem_W_en) begin
            wr_count <= wr_count + 1;
            mem[ma] <= mem_WD[7:0];
            if (mem_RW_type[1:0] != 2'b00) mem[ma + 8'd1] <= mem_WD[15:8];
            if (mem_RW_type[1:0] == 2'b10) begin
                mem[ma + 8'd2] <= mem_WD[23:16];
                mem[ma + 8'd3] <= mem_WD[31:24];
            end
        end
    end

    function automatic logic [31:0] peek(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    // driver tasks
    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    // scoreboard
    logic [31:0] exp_q[$];
    logic        exp_mis_q[$];
    int          exp_lat_q[$];

    task automatic run_req(input vec_t v, input int idx);
        int          lat;
        int          wr0;
        bit          got;
        logic [31:0] rd_addr[$];
        logic [2:0]  rd_type[$];
        logic [31:0] a0;
        logic [31:0] e_rdata;
        logic        e_mis;
        int          e_lat;
        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        check($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
        req_we = v.we; req_type = v.typ; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1;
        exp_q.push_back(v.exp_rdata);
        exp_mis_q.push_back(v.exp_mis);
        exp_lat_q.push_back(v.exp_lat);
        wr0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (mem_R_en) begin
                rd_addr.push_back(mem_addr);
                rd_type.push_back(mem_RW_type);
            end
            if (rsp_valid) got = 1'b1;
        end
        e_rdata = exp_q.pop_front();
        e_mis   = exp_mis_q.pop_front();
        e_lat   = exp_lat_q.pop_front();
        if (!got) begin
            check($sformatf("v%0d rsp_timeout", idx), 32'd0, 32'd1);
        end else begin
            check($sformatf("v%0d rdata", idx), rsp_rdata, e_rdata);
            check($sformatf("v%0d misalign", idx), {31'b0, rsp_misalign}, {31'b0, e_mis});
            check($sformatf("v%0d latency", idx), lat, e_lat);
            check($sformatf("v%0d writes", idx), wr_count - wr0, v.exp_wr);
            check($sformatf("v%0d reads", idx), rd_addr.size(), v.exp_rd);
            if (v.exp_rd == 2 && rd_addr.size() == 2) begin
                a0 = v.addr & ~32'd3;
                check($sformatf("v%0d rd0_addr", idx), rd_addr[0], a0);
                check($sformatf("v%0d rd1_addr", idx), rd_addr[1], a0 + 32'd4);
                check($sformatf("v%0d rd0_type", idx), {29'b0, rd_type[0]}, 32'd2);
                check($sformatf("v%0d rd1_type", idx), {29'b0, rd_type[1]}, 32'd2);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        int          wr0;
        bit          seen;
        logic [31:0] held;

        vecs[0]  = '{1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 0};
        vecs[1]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1};
        vecs[2]  = '{1'b0, 3'b000, 32'h23,       32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 1};
        vecs[3]  = '{1'b0, 3'b100, 32'h23,       32'h0,        32'h00000080, 1'b0, 2, 0, 1};
        vecs[4]  = '{1'b0, 3'b010, 32'h31,       32'h0,        32'h88112233, 1'b0, 3, 0, 2};
        vecs[5]  = '{1'b0, 3'b001, 32'h33,       32'h0,        32'hFFFF8811, 1'b0, 3, 0, 2};
        vecs[6]  = '{1'b0, 3'b101, 32'h33,       32'h0,        32'h00008811, 1'b0, 3, 0, 2};
        vecs[7]  = '{1'b1, 3'b001, 32'h33,       32'h0000BEEF, 32'h0,        1'b1, 1, 0, 0};
        vecs[8]  = '{1'b1, 3'b000, 32'h12,       32'h123456AB, 32'h0,        1'b0, 2, 1, 0};
        vecs[9]  = '{1'b0, 3'b010, 32'h10,       32'h0,        32'hDEABBEEF, 1'b0, 2, 0, 1};
        vecs[10] = '{1'b0, 3'b001, 32'h11,       32'h0,        32'hFFFFABBE, 1'b0, 2, 0, 1};
        vecs[11] = '{1'b0, 3'b010, 32'hFFFFFFFE, 32'h0,        32'h4567CAFE, 1'b0, 3, 0, 2};
        vecs[12] = '{1'b1, 3'b010, 32'h22,       32'hA5A5A5A5, 32'h0,        1'b1, 1, 0, 0};
        vecs[13] = '{1'b0, 3'b010, 32'h30,       32'h0,        32'h11223344, 1'b0, 2, 0, 1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst req_ready", {31'b0, req_ready}, 32'd1);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_misalign", {31'b0, rsp_misalign}, 32'd0);
        check("rst mem_en", {30'b0, mem_W_en, mem_R_en}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);

        poke(8'h20, 32'h80FF7F01);
        poke(8'h30, 32'h11223344);
        poke(8'h34, 32'h55667788);
        poke(8'hFC, 32'hCAFEF00D);
        poke(8'h00, 32'h01234567);
        poke(8'h40, 32'h0BADF00D);

        for (int i = 0; i < 14; i++) begin
            run_req(vecs[i], i);
            if (i == 7) check("misalign store left word", peek(8'h30), 32'h11223344);
        end

        // backpressure: response held 5 cycles with rsp_ready low
        @(negedge clk);
        req_we = 1'b0; req_type = 3'b010; req_addr = 32'h30; req_valid = 1'b1;
        exp_q.push_back(32'h11223344);
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("bp rsp_seen", {31'b0, seen}, 32'd1);
        held = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bp%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d rdata", i), rsp_rdata, held);
            check($sformatf("bp%0d req_ready", i), {31'b0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        check("bp exit req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("bp after req_ready", {31'b0, req_ready}, 32'd1);

        // reset during ACC1 of a store
        wr0 = wr_count;
        req_we = 1'b1; req_type = 3'b010; req_addr = 32'h40; req_wdata = 32'h55AA55AA;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstacc W_en", {31'b0, mem_W_en}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstacc state", {30'b0, dbg_state}, 32'd0);
        check("rstacc req_ready", {31'b0, req_ready}, 32'd1);
        check("rstacc rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rstacc rsp_rdata", rsp_rdata, 32'd0);
        check("rstacc mem_addr", mem_addr, 32'd0);
        check("rstacc mem_WD", mem_WD, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("rstacc no rsp", {31'b0, seen}, 32'd0);
        check("rstacc writes", wr_count - wr0, 32'd0);
        check("rstacc mem word", peek(8'h40), 32'h0BADF00D);

        run_req('{1'b0, 3'b010, 32'h40, 32'h0, 32'h0BADF00D, 1'b0, 2, 0, 1}, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
